// File: rtl/apb_pkg.sv
// Shared APB types plus the register-mode helpers used by the config register file.
// A register's mode is derived from the RO/W1C masks, and read-only takes precedence.
package apb_pkg;

  typedef logic [2:0] prot_t;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_W1C = 2'd2
  } reg_mode_e;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Pattern returned for reads that miss the register file, so a stray access is easy to spot.
  localparam logic [31:0] BAD_READ = 32'h0BAD_B10C;

  function automatic reg_mode_e reg_mode(input logic ro, input logic w1c);
    if (ro) begin
      return REG_RO;
    end else if (w1c) begin
      return REG_W1C;
    end
    return REG_RW;
  endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Wait-state counter for the APB access phase. It raises pready after WaitCycles stalled
// access cycles and rearms when a transfer completes or the master drops psel.
module apb_wait_ctrl #(
  parameter int WaitCycles = 0
) (
  input  logic pclk_i,
  input  logic preset_i,
  input  logic psel_i,
  input  logic penable_i,
  output logic pready_o
);

  localparam int CntWidth = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(WaitCycles);

  logic [CntWidth-1:0] cnt;
  logic                access;

  assign access   = psel_i & penable_i;
  assign pready_o = access & (cnt == CntLast);

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      cnt <= '0;
    end else if (!psel_i || pready_o) begin
      cnt <= '0;
    end else if (access) begin
      cnt <= cnt + CntWidth'(1);
    end
  end

endmodule

// File: rtl/apb_cfg_regs.sv
// APB register file with per-register RW/RO/W1C behaviour and programmable wait states.
// It adds hardware load/set ports and a one-cycle write-commit pulse for each register.
module apb_cfg_regs
  import apb_pkg::*;
#(
  parameter int                NoRegs     = 1,
  parameter int                AddrWidth  = 32,
  parameter int                DataWidth  = 32,
  parameter int                WaitCycles = 0,
  parameter logic [NoRegs-1:0] RoMask     = '0,
  parameter logic [NoRegs-1:0] W1cMask    = '0,
  localparam int               StrbWidth  = (DataWidth + 7) / 8,
  localparam int               WordOffset = $clog2(StrbWidth)
) (
  input  logic                               pclk_i,
  input  logic                               preset_i,
  input  logic [AddrWidth-1:0]               paddr_i,
  input  prot_t                              pprot_i,
  input  logic                               psel_i,
  input  logic                               penable_i,
  input  logic                               pwrite_i,
  input  logic [DataWidth-1:0]               pwdata_i,
  input  logic [StrbWidth-1:0]               pstrb_i,
  output logic                               pready_o,
  output logic [DataWidth-1:0]               prdata_o,
  output logic                               pslverr_o,
  input  logic [NoRegs-1:0][DataWidth-1:0]   init_i,
  input  logic [NoRegs-1:0]                  hw_we_i,
  input  logic [NoRegs-1:0][DataWidth-1:0]   hw_d_i,
  output logic [NoRegs-1:0][DataWidth-1:0]   q_o,
  output logic [NoRegs-1:0]                  wr_o
);

  if (NoRegs < 1) begin : g_chk_noregs
    $error("apb_cfg_regs: NoRegs must be at least 1");
  end
  if (AddrWidth <= WordOffset) begin : g_chk_addr
    $error("apb_cfg_regs: AddrWidth must exceed WordOffset");
  end
  if (DataWidth < 1) begin : g_chk_data
    $error("apb_cfg_regs: DataWidth must be positive");
  end
  if (WaitCycles > 255) begin : g_chk_wait
    $error("apb_cfg_regs: WaitCycles must be 0..255");
  end

  logic [NoRegs-1:0][DataWidth-1:0] reg_q;
  logic [NoRegs-1:0][DataWidth-1:0] reg_next;
  logic [NoRegs-1:0]                wr_q;
  logic [NoRegs-1:0]                sel;
  logic [NoRegs-1:0]                wr_hit;
  logic [NoRegs-1:0]                is_rw;
  logic [NoRegs-1:0]                is_w1c;
  logic [AddrWidth-1:0]             word_addr;
  logic [DataWidth-1:0]             strb_bits;
  logic [DataWidth-1:0]             rd_mux;
  logic                             in_range;
  logic                             ro_hit;
  logic                             err;
  logic                             pready;
  logic                             commit;
  logic                             unused_prot;

  assign unused_prot = ^pprot_i;

  apb_wait_ctrl #(
    .WaitCycles(WaitCycles)
  ) u_wait (
    .pclk_i   (pclk_i),
    .preset_i (preset_i),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .pready_o (pready)
  );

  assign word_addr = paddr_i >> WordOffset;

  // One-hot decode. An address past the last register selects nothing, which is the range check.
  for (genvar gi = 0; gi < NoRegs; gi++) begin : g_reg_cfg
    localparam reg_mode_e Mode = reg_mode(RoMask[gi], W1cMask[gi]);
    assign sel[gi]    = (word_addr == AddrWidth'(gi));
    assign is_rw[gi]  = (Mode == REG_RW);
    assign is_w1c[gi] = (Mode == REG_W1C);
  end

  for (genvar gi = 0; gi < DataWidth; gi++) begin : g_strb
    assign strb_bits[gi] = pstrb_i[gi / 8];
  end

  assign in_range = |sel;
  assign ro_hit   = |(sel & RoMask);
  assign err      = ~in_range | (pwrite_i & ro_hit);
  assign commit   = pready & pwrite_i & ~err & (|pstrb_i);
  assign wr_hit   = {NoRegs{commit}} & sel;

  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < NoRegs; r++) begin
      if (sel[r]) begin
        rd_mux = rd_mux | reg_q[r];
      end
    end
  end

  // Hardware updates are applied after the APB write so that a load overrides the write, and a W1C set beats a clear.
  always_comb begin
    reg_next = reg_q;
    for (int r = 0; r < NoRegs; r++) begin
      if (is_w1c[r]) begin
        reg_next[r] = (reg_q[r] & ~(wr_hit[r] ? (pwdata_i & strb_bits) : '0))
                    | (hw_we_i[r] ? hw_d_i[r] : '0);
      end else begin
        if (wr_hit[r] && is_rw[r]) begin
          reg_next[r] = (reg_q[r] & ~strb_bits) | (pwdata_i & strb_bits);
        end
        if (hw_we_i[r]) begin
          reg_next[r] = hw_d_i[r];
        end
      end
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      reg_q <= init_i;
    end else begin
      reg_q <= reg_next;
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wr_q <= '0;
    end else begin
      wr_q <= wr_hit;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (pready && !pwrite_i) begin
      prdata_o = in_range ? rd_mux : DataWidth'(BAD_READ);
    end
  end

  assign pready_o  = pready;
  assign pslverr_o = (pready && err) ? RESP_SLVERR : RESP_OKAY;
  assign q_o       = reg_q;
  assign wr_o      = wr_q;

endmodule
